// File: rtl/cla16_pipe_addsub_if.sv
// Handshake and data bundle for the pipelined CLA adder/subtractor.
// slave is the adder side, master is the producer/consumer side.
interface cla16_pipe_addsub_if #(
    parameter int NGROUP = 4
) ();
    localparam int W = 4 * NGROUP;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ci;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] s;
    logic         cout;
    logic         ovf;
    logic         zero;

    modport slave (
        input  in_valid, a, b, ci, sub, out_ready,
        output in_ready, out_valid, s, cout, ovf, zero
    );

    modport master (
        output in_valid, a, b, ci, sub, out_ready,
        input  in_ready, out_valid, s, cout, ovf, zero
    );
endinterface

// File: rtl/cla16_pipe_addsub.sv
// Two-stage carry-lookahead adder/subtractor: S1 registers per-group pp/gg and
// raw p/g bits, S2 resolves group carries and registers sum/flags.
module cla16_pipe_addsub #(
    parameter int NGROUP = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    cla16_pipe_addsub_if.slave      bus
);
    localparam int W = 4 * NGROUP;

    // Stage 1 combinational: operand conditioning and group generate/propagate
    logic [W-1:0]      bx, p_d, g_d;
    logic [NGROUP-1:0] pp_d, gg_d;
    logic              c0_d;

    always_comb begin
        bx   = bus.b ^ {W{bus.sub}};
        p_d  = bus.a ^ bx;
        g_d  = bus.a & bx;
        c0_d = bus.sub | bus.ci;
        pp_d = '0;
        gg_d = '0;
        for (int k = 0; k < NGROUP; k++) begin
            pp_d[k] = &p_d[4*k +: 4];
            gg_d[k] = g_d[4*k+3] | (p_d[4*k+3] & (g_d[4*k+2] | (p_d[4*k+2] &
                      (g_d[4*k+1] | (p_d[4*k+1] & g_d[4*k])))));
        end
    end

    logic [W-1:0]      p_q, g_q;
    logic [NGROUP-1:0] pp_q, gg_q;
    logic              c0_q;
    logic              s1_vld_q, s2_vld_q;

    // Handshake: in_ready depends combinationally on out_ready (no skid buffer)
    logic s2_free, s1_adv, in_rdy, s1_load;
    assign s2_free = !s2_vld_q | bus.out_ready;
    assign s1_adv  = s1_vld_q & s2_free;
    assign in_rdy  = !s1_vld_q | s1_adv;
    assign s1_load = bus.in_valid & in_rdy;

    // Stage 2 combinational: second-level lookahead, then ripple inside each group
    logic [W-1:0] carr;
    logic [W-1:0] s_d;
    logic         cg, cr;
    logic         cout_d, ovf_d, zero_d;

    always_comb begin
        carr = '0;
        cg   = c0_q;
        cr   = 1'b0;
        for (int k = 0; k < NGROUP; k++) begin
            cr = cg;
            for (int i = 0; i < 4; i++) begin
                carr[4*k+i] = cr;
                cr = g_q[4*k+i] | (p_q[4*k+i] & cr);
            end
            cg = gg_q[k] | (pp_q[k] & cg);
        end
        s_d    = p_q ^ carr;
        cout_d = cg;
        ovf_d  = carr[W-1] ^ cg;
        zero_d = (s_d == '0);
    end

    logic [W-1:0] s_q;
    logic         cout_q, ovf_q, zero_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_vld_q <= 1'b0;
            s2_vld_q <= 1'b0;
            p_q      <= '0;
            g_q      <= '0;
            pp_q     <= '0;
            gg_q     <= '0;
            c0_q     <= 1'b0;
            s_q      <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            if (in_rdy)
                s1_vld_q <= bus.in_valid;
            if (s1_load) begin
                p_q  <= p_d;
                g_q  <= g_d;
                pp_q <= pp_d;
                gg_q <= gg_d;
                c0_q <= c0_d;
            end
            if (s2_free)
                s2_vld_q <= s1_vld_q;
            // Results only update on a real transfer, so they hold while idle or stalled
            if (s1_adv) begin
                s_q    <= s_d;
                cout_q <= cout_d;
                ovf_q  <= ovf_d;
                zero_q <= zero_d;
            end
        end
    end

    assign bus.in_ready  = in_rdy;
    assign bus.out_valid = s2_vld_q;
    assign bus.s         = s_q;
    assign bus.cout      = cout_q;
    assign bus.ovf       = ovf_q;
    assign bus.zero      = zero_q;
endmodule

// File: tb/tb_cla16_pipe_addsub.sv
// Directed-vector bench for cla16_pipe_addsub with an in-order scoreboard.
`timescale 1ns/1ps
module tb_cla16_pipe_addsub;
    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic        ci;
        logic        sub;
        logic [18:0] exp;   // {s, cout, ovf, zero}
    } rec_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    cla16_pipe_addsub_if #(.NGROUP(4)) bus ();
    cla16_pipe_addsub #(.NGROUP(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

    int   n_checks = 0;
    int   n_fail   = 0;
    rec_t cur_exp;
    rec_t expq[$];

    function automatic rec_t mk(input logic [15:0] a, b, input logic ci, sub,
                                input logic [15:0] s, input logic c, o, z);
        rec_t r;
        r.a = a; r.b = b; r.ci = ci; r.sub = sub; r.exp = {s, c, o, z};
        return r;
    endfunction

    // Reference: plain wide add; ovf from carry into bit 15 vs carry out
    function automatic rec_t model(input logic [15:0] a, b, input logic ci, sub);
        logic [15:0] bx;
        logic        c0;
        logic [16:0] f;
        logic [15:0] lo;
        bx = sub ? ~b : b;
        c0 = sub | ci;
        f  = {1'b0, a} + {1'b0, bx} + {16'd0, c0};
        lo = {1'b0, a[14:0]} + {1'b0, bx[14:0]} + {15'd0, c0};
        return mk(a, b, ci, sub, f[15:0], f[16], lo[15] ^ f[16], f[15:0] == 16'h0);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: transfers are decided by handshake values stable at the negedge
    always @(negedge clk) begin
        if (!rst_n) begin
            expq.delete();
        end else begin
            if (bus.in_valid && bus.in_ready)
                expq.push_back(cur_exp);
            if (bus.out_valid && bus.out_ready) begin
                n_checks++;
                if (expq.size() == 0) begin
                    n_fail++;
                    $display("FAIL out_unexpected: got s=%0h with no beat outstanding", bus.s);
                end else begin
                    rec_t e;
                    e = expq.pop_front();
                    if ({bus.s, bus.cout, bus.ovf, bus.zero} !== e.exp) begin
                        n_fail++;
                        $display("FAIL out_beat a=%0h b=%0h ci=%0b sub=%0b: got s/c/o/z=%0h/%0b/%0b/%0b expected %0h/%0b/%0b/%0b",
                                 e.a, e.b, e.ci, e.sub, bus.s, bus.cout, bus.ovf, bus.zero,
                                 e.exp[18:3], e.exp[2], e.exp[1], e.exp[0]);
                    end
                end
            end
        end
    end

    task automatic drive(input rec_t r);
        bus.a = r.a; bus.b = r.b; bus.ci = r.ci; bus.sub = r.sub;
        cur_exp = r;
        bus.in_valid = 1'b1;
    endtask

    task automatic send(input rec_t r, output int waited);
        logic done;
        done = 1'b0;
        waited = 0;
        drive(r);
        for (int t = 0; t < 50 && !done; t++) begin
            @(negedge clk);
            if (bus.in_ready) done = 1'b1;
            else waited++;
            @(posedge clk); #1;
        end
        if (!done) chk("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        for (int t = 0; t < 20 && expq.size() != 0; t++) @(negedge clk);
        chk("drain_outstanding", expq.size(), 0);
        @(posedge clk); #1;
    endtask

    rec_t tbl[12];
    rec_t bp[4];
    int   w, wsum;
    int   idx;
    logic acc;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = mk(16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1);
        tbl[1]  = mk(16'h0008, 16'h0001, 1'b1, 1'b0, 16'h000A, 1'b0, 1'b0, 1'b0);
        tbl[2]  = mk(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);
        tbl[3]  = mk(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0);
        tbl[4]  = mk(16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);
        tbl[5]  = mk(16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
        tbl[6]  = mk(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
        tbl[7]  = mk(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
        tbl[8]  = mk(16'h1234, 16'h1234, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1);
        tbl[9]  = mk(16'h0000, 16'h0001, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0);
        tbl[10] = mk(16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0);
        tbl[11] = mk(16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0);
        bp[0]   = mk(16'h1111, 16'h2222, 1'b0, 1'b0, 16'h3333, 1'b0, 1'b0, 1'b0);
        bp[1]   = mk(16'h0100, 16'h0001, 1'b0, 1'b1, 16'h00FF, 1'b1, 1'b0, 1'b0);
        bp[2]   = mk(16'h4000, 16'h4000, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
        bp[3]   = mk(16'hABCD, 16'h0003, 1'b1, 1'b0, 16'hABD1, 1'b0, 1'b0, 1'b0);

        // Reset held two cycles with a beat offered
        rst_n = 1'b0;
        bus.out_ready = 1'b1;
        drive(mk(16'h1234, 16'h0001, 1'b0, 1'b0, 16'h1235, 1'b0, 1'b0, 1'b0));
        @(posedge clk); @(posedge clk); #1;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_s", bus.s, 0);
        chk("rst_flags", {bus.cout, bus.ovf, bus.zero}, 0);
        rst_n = 1'b1;
        bus.in_valid = 1'b0;
        #1;
        chk("post_rst_in_ready", bus.in_ready, 1);

        // Latency: offered now, accepted at next edge, visible after the one after
        drive(tbl[1]);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        chk("lat_edge1_out_valid", bus.out_valid, 0);
        @(posedge clk); #1;
        chk("lat_edge2_out_valid", bus.out_valid, 1);
        chk("lat_edge2_s", bus.s, 16'h000A);
        drain();

        // Directed table, streamed back to back
        foreach (tbl[i]) send(tbl[i], w);
        bus.in_valid = 1'b0;
        drain();

        // 100 random beats; full throughput means no wait cycles at all
        wsum = 0;
        for (int i = 0; i < 100; i++) begin
            logic [15:0] ra, rb;
            logic        rc, rs;
            ra = 16'($urandom); rb = 16'($urandom);
            rc = 1'($urandom);  rs = 1'($urandom);
            send(model(ra, rb, rc, rs), w);
            wsum += w;
        end
        bus.in_valid = 1'b0;
        chk("stream_wait_cycles", wsum, 0);
        drain();

        // Backpressure: two beats fill the pipe, then in_ready drops and outputs hold
        bus.out_ready = 1'b0;
        idx = 0;
        drive(bp[0]);
        for (int cyc = 0; cyc < 5; cyc++) begin
            @(negedge clk);
            acc = bus.in_ready;
            if (cyc >= 2) begin
                chk("bp_in_ready", bus.in_ready, 0);
                chk("bp_out_valid", bus.out_valid, 1);
                chk("bp_hold", {bus.s, bus.cout, bus.ovf, bus.zero}, bp[0].exp);
            end
            @(posedge clk); #1;
            if (acc) begin
                idx++;
                drive(bp[idx]);
            end
        end
        chk("bp_accepted", idx, 2);
        bus.out_ready = 1'b1;
        send(bp[2], w);
        send(bp[3], w);
        bus.in_valid = 1'b0;
        drain();

        // Reset with two beats in flight: nothing may emerge afterwards
        bus.out_ready = 1'b0;
        send(tbl[10], w);
        send(tbl[7], w);
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        chk("midrst_out_valid", bus.out_valid, 0);
        chk("midrst_s", bus.s, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("midrst_idle_out_valid", bus.out_valid, 0);
        end
        @(posedge clk); #1;
        send(tbl[3], w);
        bus.in_valid = 1'b0;
        drain();

        $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
        $finish;
    end
endmodule
